// File: rtl/serial_data_to_bram.sv
// ---------------------------------------------------------------------------
// serial_data_to_bram
//   Collects 1-4 bytes from a UART RX FIFO into one 32-bit word and issues a
//   single byte-masked write to a BRAM port. Lanes are filled from lane 3 down
//   to lane 0, so the first received byte lands in bram_data[31:24].
//
// Ports
//   clk                      system clock, rising edge
//   rst                      asynchronous active-low reset
//   enable                   start pulse (sampled only while idle)
//   bytes_to_write[3:0]      byte-lane mask to fill and write
//   write_addr               BRAM word address, latched at start
//   write_complete           one-cycle pulse when the transfer ends
//   uart_data_in[7:0]        FIFO head byte
//   uart_data_present        FIFO non-empty
//   uart_data_read           one-cycle FIFO pop strobe
//   bram_data[31:0]          assembled word (held until next start)
//   bram_write_enable        one-cycle BRAM write strobe
//   bram_write_enable_bytes  latched byte mask
//   bram_write_addr          latched address
// ---------------------------------------------------------------------------
module serial_data_to_bram #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [3:0]            bytes_to_write,
    output logic                  write_complete,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [7:0]            uart_data_in,
    input  logic                  uart_data_present,
    output logic                  uart_data_read,
    output logic [DATA_WIDTH-1:0] bram_data,
    output logic                  bram_write_enable,
    output logic [3:0]            bram_write_enable_bytes,
    output logic [ADDR_WIDTH-1:0] bram_write_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_WAIT_BYTE,
        S_SETTLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [3:0]            r_pending;   // lanes still to be filled
    logic [1:0]            r_lane;      // lane currently being filled
    logic [3:0]            r_mask;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_read;
    logic                  r_we;
    logic                  r_done;

    logic [1:0]            w_lane;
    logic                  w_any;

    // Highest pending lane wins: ascending scan, later hits overwrite.
    always_comb begin
        w_lane = 2'd0;
        w_any  = |r_pending;
        for (int i = 0; i < 4; i++) begin
            if (r_pending[i]) w_lane = 2'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_pending <= 4'd0;
            r_lane    <= 2'd0;
            r_mask    <= 4'd0;
            r_addr    <= '0;
            r_data    <= '0;
            r_read    <= 1'b0;
            r_we      <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            // strobes default low; each is raised for a single cycle below
            r_read <= 1'b0;
            r_we   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (enable) begin
                        r_mask    <= bytes_to_write;
                        r_pending <= bytes_to_write;
                        r_addr    <= write_addr;
                        r_data    <= '0;
                        r_state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_any) begin
                        r_lane  <= w_lane;
                        r_state <= S_WAIT_BYTE;
                    end else if (r_mask == 4'd0) begin
                        // nothing collected, so no BRAM write either
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_WRITE;
                    end
                end
                S_WAIT_BYTE: begin
                    if (uart_data_present) begin
                        r_data[{r_lane, 3'b000} +: 8] <= uart_data_in;
                        r_pending[r_lane]             <= 1'b0;
                        r_read                        <= 1'b1;
                        r_state                       <= S_SETTLE;
                    end
                end
                // dead cycle: lets the FIFO update present/data after the pop
                S_SETTLE: r_state <= S_SELECT;
                S_WRITE: begin
                    r_we    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign write_complete          = r_done;
    assign uart_data_read          = r_read;
    assign bram_data               = r_data;
    assign bram_write_enable       = r_we;
    assign bram_write_enable_bytes = r_mask;
    assign bram_write_addr         = r_addr;

endmodule

// File: tb/tb_serial_data_to_bram.sv
module tb_serial_data_to_bram;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  bytes_to_write = 4'd0;
    logic        write_complete;
    logic [31:0] write_addr = 32'd0;
    logic [7:0]  uart_data_in = 8'd0;
    logic        uart_data_present = 1'b0;
    logic        uart_data_read;
    logic [31:0] bram_data;
    logic        bram_write_enable;
    logic [3:0]  bram_write_enable_bytes;
    logic [31:0] bram_write_addr;

    serial_data_to_bram #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .enable(enable), .bytes_to_write(bytes_to_write),
        .write_complete(write_complete), .write_addr(write_addr),
        .uart_data_in(uart_data_in), .uart_data_present(uart_data_present),
        .uart_data_read(uart_data_read), .bram_data(bram_data),
        .bram_write_enable(bram_write_enable),
        .bram_write_enable_bytes(bram_write_enable_bytes),
        .bram_write_addr(bram_write_addr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // FIFO model feeding the DUT
    logic [7:0] fifo[$];
    logic [7:0] pushed[$];
    bit   gate = 1'b1;
    bit   rnd_gate = 1'b0;

    // observations
    int cyc = 0, c0 = 0;
    int reads = 0, we_cnt = 0, wc_cnt = 0, we_at = -1, wc_at = -1;
    logic [31:0] cap_data, cap_addr;
    logic [3:0]  cap_bytes;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] all_outs();
        return {9'd0, write_complete, uart_data_read, bram_data, bram_write_enable,
                bram_write_enable_bytes, bram_write_addr};
    endfunction

    // expected word: mask lanes filled from lane 3 down, in arrival order
    function automatic logic [31:0] model_word(input logic [3:0] m, input logic [7:0] b[$]);
        logic [31:0] w = 32'd0;
        int k = 0;
        for (int l = 3; l >= 0; l--) begin
            if (m[l]) begin
                w[8*l +: 8] = b[k];
                k++;
            end
        end
        return w;
    endfunction

    function automatic int popc(input logic [3:0] m);
        return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
    endfunction

    // one clock: observe at the falling edge, then update FIFO-side inputs
    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (uart_data_read === 1'b1) begin
            chk("read_while_present", {79'd0, uart_data_present}, 80'd1);
            reads++;
            if (fifo.size() > 0) void'(fifo.pop_front());
        end
        if (bram_write_enable === 1'b1) begin
            we_cnt++;
            we_at     = cyc - c0;
            cap_data  = bram_data;
            cap_bytes = bram_write_enable_bytes;
            cap_addr  = bram_write_addr;
        end
        if (write_complete === 1'b1) begin
            wc_cnt++;
            wc_at = cyc - c0;
        end
        if (rnd_gate) gate = ($urandom_range(2) != 0);
        uart_data_in      = (fifo.size() > 0) ? fifo[0] : 8'h5A;
        uart_data_present = gate && (fifo.size() > 0);
    endtask

    task automatic start(input logic [3:0] m, input logic [31:0] a);
        reads = 0; we_cnt = 0; wc_cnt = 0; we_at = -1; wc_at = -1;
        enable = 1'b1; bytes_to_write = m; write_addr = a;
        c0 = cyc + 1;
        cycle();
        enable = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (wc_cnt != 0) break;
            cycle();
        end
        chk("done_timeout", 80'(wc_cnt), 80'd1);
    endtask

    task automatic load_bytes(input int n, input logic [7:0] v, input bit rnd);
        pushed.delete();
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = rnd ? 8'($urandom) : v;
            pushed.push_back(b);
            fifo.push_back(b);
        end
    endtask

    initial begin
        logic [3:0]  m;
        logic [31:0] a;
        int          n;

        // ---- reset / idle ----
        #100;
        chk("reset_outs", all_outs(), 80'd0);
        @(negedge clk);
        rst = 1'b1;
        fifo.push_back(8'hAA);
        uart_data_in = 8'hAA; uart_data_present = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        chk("idle_reads", 80'(reads), 80'd0);
        chk("idle_outs", all_outs(), 80'd0);
        fifo.delete();

        // ---- mask 1010, addr 1, data 2, continuous ----
        load_bytes(2, 8'h02, 1'b0);
        start(4'b1010, 32'd1);
        wait_done(100);
        chk("t1_reads", 80'(reads), 80'd2);
        chk("t1_data", 80'(cap_data), 80'h02000200);
        chk("t1_bytes", 80'(cap_bytes), 80'b1010);
        chk("t1_addr", 80'(cap_addr), 80'd1);
        chk("t1_we_at", 80'(we_at), 80'(3*2 + 2));
        chk("t1_wc_at", 80'(wc_at), 80'(3*2 + 3));
        for (int i = 0; i < 5; i++) cycle();
        chk("t1_single_we", 80'(we_cnt), 80'd1);
        chk("t1_hold", {16'd0, bram_data, bram_write_addr}, {16'd0, 32'h02000200, 32'd1});

        // ---- mask 1110, addr 2, data 3, FIFO runs dry after two bytes ----
        fifo.delete();
        load_bytes(2, 8'h03, 1'b0);
        start(4'b1110, 32'd2);
        for (int i = 0; i < 30; i++) cycle();
        chk("t2_stall_reads", 80'(reads), 80'd2);
        chk("t2_stall_nowrite", 80'({we_cnt, wc_cnt}), 80'd0);
        fifo.push_back(8'h03);
        wait_done(50);
        chk("t2_reads", 80'(reads), 80'd3);
        chk("t2_data", 80'(cap_data), 80'h03030300);
        chk("t2_bytes_addr", 80'({cap_bytes, cap_addr}), 80'({4'b1110, 32'd2}));

        // ---- mask 1111, addr 3, data 4, enable re-pulsed mid-transfer ----
        fifo.delete();
        load_bytes(4, 8'h04, 1'b0);
        start(4'b1111, 32'd3);
        for (int i = 0; i < 3; i++) cycle();
        enable = 1'b1; bytes_to_write = 4'b0001; write_addr = 32'd9;
        cycle();
        enable = 1'b0;
        wait_done(100);
        chk("t3_reads", 80'(reads), 80'd4);
        chk("t3_data", 80'(cap_data), 80'h04040404);
        chk("t3_bytes_addr", 80'({cap_bytes, cap_addr}), 80'({4'b1111, 32'd3}));
        chk("t3_we_at", 80'(we_at), 80'(3*4 + 2));
        for (int i = 0; i < 10; i++) cycle();
        chk("t3_no_requeue", 80'({we_cnt, wc_cnt}), 80'({32'd1, 32'd1}));

        // ---- mask 0000, addr 5 ----
        fifo.delete();
        fifo.push_back(8'h77);
        start(4'b0000, 32'd5);
        wait_done(20);
        chk("t4_wc_at", 80'(wc_at), 80'd2);
        for (int i = 0; i < 4; i++) cycle();
        chk("t4_no_we_no_read", 80'({we_cnt, reads}), 80'd0);
        chk("t4_data_cleared", 80'({bram_data, bram_write_addr}), 80'({32'd0, 32'd5}));
        fifo.delete();

        // ---- reset mid-transfer ----
        load_bytes(4, 8'h06, 1'b0);
        start(4'b1111, 32'd7);
        for (int i = 0; i < 40; i++) begin
            if (reads >= 2) break;
            cycle();
        end
        chk("t5_two_reads", 80'(reads), 80'd2);
        rst = 1'b0;
        #1;
        chk("t5_reset_outs", all_outs(), 80'd0);
        for (int i = 0; i < 3; i++) cycle();
        chk("t5_no_write", 80'({we_cnt, wc_cnt}), 80'd0);
        fifo.delete();
        rst = 1'b1;
        cycle();
        load_bytes(1, 8'h05, 1'b0);
        start(4'b0001, 32'd4);
        wait_done(50);
        chk("t5_reads", 80'(reads), 80'd1);
        chk("t5_data", 80'(cap_data), 80'h00000005);
        chk("t5_bytes_addr", 80'({cap_bytes, cap_addr}), 80'({4'b0001, 32'd4}));

        // ---- randomized transfers against the model ----
        for (int t = 0; t < 25; t++) begin
            fifo.delete();
            m = 4'($urandom);
            a = $urandom;
            n = popc(m);
            rnd_gate = (t % 2 == 1);
            gate = 1'b1;
            load_bytes(n, 8'h00, 1'b1);
            start(m, a);
            wait_done(400);
            rnd_gate = 1'b0;
            chk("rnd_reads", 80'(reads), 80'(n));
            chk("rnd_we_cnt", 80'(we_cnt), (n == 0) ? 80'd0 : 80'd1);
            chk("rnd_data", 80'(bram_data), 80'(model_word(m, pushed)));
            chk("rnd_bytes_addr", 80'({bram_write_enable_bytes, bram_write_addr}), 80'({m, a}));
            if (n != 0) begin
                chk("rnd_wc_follows_we", 80'(wc_at), 80'(we_at + 1));
                if (t % 2 == 0) chk("rnd_latency", 80'(we_at), 80'(3*n + 2));
            end else begin
                chk("rnd_empty_wc_at", 80'(wc_at), 80'd2);
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
